// File: rtl/fib_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fib_pkg
// Purpose  : Shared types and width constants for the Fibonacci controller
//            and its datapath.
//            - fib_state_t : controller state encoding
//            - FIB_W_N     : index width
//            - FIB_W_F     : Fibonacci value width
//            - FIB_N_MAX   : largest index whose F(n) fits in FIB_W_F bits
// Revision : 1.0 - initial release
// ============================================================================
package fib_pkg;

    localparam int FIB_W_N   = 5;
    localparam int FIB_W_F   = 16;
    // F(24) = 46368 is the last Fibonacci number below 2**16.
    localparam int FIB_N_MAX = 24;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        LOAD  = 3'd2,
        INIT  = 3'd3,
        RUN   = 3'd4,
        DONE  = 3'd5
    } fib_state_t;

endpackage : fib_pkg
`default_nettype wire

// File: rtl/fib_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fib_seq_ctrl
// Purpose  : Sequencing controller for the Fibonacci datapath. Accepts an
//            index over a start/done/ack handshake, strobes the datapath to
//            compute F(n), captures the result and flags indices whose
//            result would not fit in W_F bits.
// Ports    : clk        - clock, rising edge
//            reset      - asynchronous reset, active low
//            start      - request strobe (sampled in IDLE only)
//            n_in       - requested index (sampled with start)
//            ack        - host consumed result (sampled in DONE only)
//            count      - datapath counter value
//            count_to   - datapath target-index register value
//            nth_fib    - datapath current Fibonacci value
//            dp_clr     - one-cycle datapath clear pulse
//            enb        - load datapath count_to register
//            first_time - select seed values in the datapath
//            count_enb  - advance datapath counter and value registers
//            busy       - computation in progress
//            done       - result/err valid, held until ack
//            err        - requested index out of range
//            result     - F(n), stable while done is high
// Revision : 1.0 - initial release
// ============================================================================
module fib_seq_ctrl
    import fib_pkg::*;
#(
    parameter int W_N   = FIB_W_N,
    parameter int W_F   = FIB_W_F,
    parameter int N_MAX = FIB_N_MAX
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [W_N-1:0] n_in,
    input  logic           ack,
    input  logic [W_N-1:0] count,
    input  logic [W_N-1:0] count_to,
    input  logic [W_F-1:0] nth_fib,
    output logic           dp_clr,
    output logic           enb,
    output logic           first_time,
    output logic           count_enb,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [W_F-1:0] result
);

    localparam logic [W_N-1:0] c_n_max = W_N'(N_MAX);

    fib_state_t     r_state;
    fib_state_t     w_state_nxt;
    logic [W_N-1:0] r_n_q;
    logic [W_F-1:0] r_result;
    logic           r_err;

    logic           w_n_over;
    logic           w_run_hit;

    assign w_n_over  = (n_in > c_n_max);
    // The datapath counter reaching its target means nth_fib now holds F(n).
    assign w_run_hit = (count == count_to);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and strobe decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        dp_clr      = 1'b0;
        enb         = 1'b0;
        first_time  = 1'b0;
        count_enb   = 1'b0;
        done        = 1'b0;
        busy        = (r_state != IDLE) && (r_state != DONE);

        case (r_state)
            IDLE: begin
                if (start) begin
                    // Out-of-range requests skip the datapath entirely.
                    w_state_nxt = w_n_over ? DONE : CLEAR;
                end
            end
            CLEAR: begin
                dp_clr      = 1'b1;
                w_state_nxt = LOAD;
            end
            LOAD: begin
                enb         = 1'b1;
                w_state_nxt = (r_n_q == '0) ? DONE : INIT;
            end
            INIT: begin
                // Seeds current=F(1), prev=0 and steps count 0->1.
                count_enb   = 1'b1;
                first_time  = 1'b1;
                w_state_nxt = RUN;
            end
            RUN: begin
                if (w_run_hit) begin
                    w_state_nxt = DONE;
                end else begin
                    count_enb = 1'b1;
                end
            end
            DONE: begin
                done = 1'b1;
                // ack has priority over a simultaneous start: go back to
                // IDLE and let the next start be sampled there.
                if (ack) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Request index, result and error registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_n_q    <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_n_over) begin
                            r_err    <= 1'b1;
                            r_result <= '0;
                        end else begin
                            r_n_q <= n_in;
                            r_err <= 1'b0;
                        end
                    end
                end
                LOAD: begin
                    if (r_n_q == '0) begin
                        r_result <= '0;
                    end
                end
                RUN: begin
                    if (w_run_hit) begin
                        r_result <= nth_fib;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign err    = r_err;
    assign result = r_result;

endmodule : fib_seq_ctrl
`default_nettype wire

// File: tb/tb_fib_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fib_seq_ctrl
// Purpose  : Directed self-checking bench for fib_seq_ctrl. A behavioural
//            Fibonacci datapath is wired beside the controller so that
//            count/count_to/nth_fib respond to the controller strobes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fib_seq_ctrl;

    localparam int c_w_n = 5;
    localparam int c_w_f = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [c_w_n-1:0] n_in = '0;
    logic             ack = 1'b0;
    logic [c_w_n-1:0] count;
    logic [c_w_n-1:0] count_to;
    logic [c_w_f-1:0] nth_fib;
    logic             dp_clr;
    logic             enb;
    logic             first_time;
    logic             count_enb;
    logic             busy;
    logic             done;
    logic             err;
    logic [c_w_f-1:0] result;

    logic [c_w_f-1:0] r_prev;

    int n_checks = 0;
    int n_fail   = 0;
    int ce_cnt   = 0;
    int en_cnt   = 0;
    int clr_cnt  = 0;

    always #5 clk = ~clk;

    fib_seq_ctrl #(
        .W_N   (c_w_n),
        .W_F   (c_w_f),
        .N_MAX (24)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .n_in       (n_in),
        .ack        (ack),
        .count      (count),
        .count_to   (count_to),
        .nth_fib    (nth_fib),
        .dp_clr     (dp_clr),
        .enb        (enb),
        .first_time (first_time),
        .count_enb  (count_enb),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .result     (result)
    );

    // Behavioural datapath: counter, target register, current/prev values.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            count_to <= '0;
            nth_fib  <= '0;
            r_prev   <= '0;
        end else if (dp_clr) begin
            count    <= '0;
            count_to <= '0;
            nth_fib  <= '0;
            r_prev   <= '0;
        end else begin
            if (enb) begin
                count_to <= n_in;
            end
            if (count_enb) begin
                count <= count + 1'b1;
                if (first_time) begin
                    nth_fib <= 16'd1;
                    r_prev  <= 16'd0;
                end else begin
                    nth_fib <= nth_fib + r_prev;
                    r_prev  <= nth_fib;
                end
            end
        end
    end

    // Strobe pulse counters (value in the cycle ending at this edge).
    always @(posedge clk) begin
        ce_cnt  <= ce_cnt + int'(count_enb);
        en_cnt  <= en_cnt + int'(enb);
        clr_cnt <= clr_cnt + int'(dp_clr);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issue a request at the next negedge; returns cycles from the sampling
    // edge until done is seen. A start pulse with a different index is
    // injected at cycle 'glitch' (0 = never).
    task automatic do_req(input logic [c_w_n-1:0] n, input int glitch, output int lat);
        @(negedge clk);
        n_in  = n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 200) begin
            if (lat == glitch) begin
                start = 1'b1;
                n_in  = 5'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
    endtask

    task automatic do_ack(input string tag);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check({tag, "_done_low"}, 32'(done), 32'd0);
    endtask

    int lat;
    int ce0, en0, clr0;
    bit stable;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_outs", {26'd0, dp_clr, enb, first_time, count_enb, busy, done}, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        reset = 1'b1;

        // n=10
        ce0 = ce_cnt; en0 = en_cnt; clr0 = clr_cnt;
        do_req(5'd10, 0, lat);
        check("n10_lat", 32'(lat), 32'd14);
        check("n10_result", 32'(result), 32'd55);
        check("n10_err", 32'(err), 32'd0);
        check("n10_ce_pulses", 32'(ce_cnt - ce0), 32'd10);
        check("n10_enb_pulses", 32'(en_cnt - en0), 32'd1);
        check("n10_clr_pulses", 32'(clr_cnt - clr0), 32'd1);
        do_ack("n10");

        // n=0 then n=1
        ce0 = ce_cnt;
        do_req(5'd0, 0, lat);
        check("n0_lat", 32'(lat), 32'd3);
        check("n0_result", 32'(result), 32'd0);
        check("n0_ce_pulses", 32'(ce_cnt - ce0), 32'd0);
        do_ack("n0");
        do_req(5'd1, 0, lat);
        check("n1_lat", 32'(lat), 32'd5);
        check("n1_result", 32'(result), 32'd1);
        do_ack("n1");

        // Largest legal index, then first illegal one
        do_req(5'd24, 0, lat);
        check("n24_lat", 32'(lat), 32'd28);
        check("n24_result", 32'(result), 32'd46368);
        check("n24_err", 32'(err), 32'd0);
        do_ack("n24");
        ce0 = ce_cnt; en0 = en_cnt; clr0 = clr_cnt;
        do_req(5'd25, 0, lat);
        check("n25_lat", 32'(lat), 32'd1);
        check("n25_err", 32'(err), 32'd1);
        check("n25_result", 32'(result), 32'd0);
        check("n25_strobes", 32'((ce_cnt - ce0) + (en_cnt - en0) + (clr_cnt - clr0)), 32'd0);
        do_ack("n25");

        // start during RUN ignored; result held while ack stays low
        do_req(5'd12, 6, lat);
        check("glitch_lat", 32'(lat), 32'd16);
        check("glitch_result", 32'(result), 32'd144);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!done || result != 16'd144) stable = 1'b0;
        end
        check("hold_stable", 32'(stable), 32'd1);
        do_ack("hold");

        // Asynchronous reset mid-RUN
        @(negedge clk);
        n_in  = 5'd15;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("midrun_busy", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("async_outs", {26'd0, dp_clr, enb, first_time, count_enb, busy, done}, 32'd0);
        check("async_result", 32'(result), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        do_req(5'd7, 0, lat);
        check("n7_lat", 32'(lat), 32'd11);
        check("n7_result", 32'(result), 32'd13);
        do_ack("n7");

        // ack and start together in DONE: ack wins, next start accepted
        do_req(5'd3, 0, lat);
        check("n3_result", 32'(result), 32'd2);
        ack   = 1'b1;
        start = 1'b1;
        n_in  = 5'd4;
        @(negedge clk);
        ack = 1'b0;
        check("ackstart_idle", {30'd0, busy, done}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        check("ackstart_busy", 32'(busy), 32'd1);
        lat = 1;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("n4_lat", 32'(lat), 32'd8);
        check("n4_result", 32'(result), 32'd3);
        do_ack("n4");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fib_seq_ctrl
`default_nettype wire
